// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM stage: funct3 access sizes, result_src selector, MEM FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_LOAD = 2'b01,
    RS_PC4  = 2'b10
  } result_src_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the data bus: store enables/replication, load extract/extend,
// and detection of misaligned or illegal-size accesses.
module load_store_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata_ext,
  output logic            err
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be        = 4'b0000;
    wdata     = rs2;
    rdata_ext = rdata;
    err       = 1'b0;
    byte_v    = rdata[{off, 3'b000} +: 8];
    half_v    = off[1] ? rdata[31:16] : rdata[15:0];

    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {(XLEN/8){rs2[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << off;
        wdata = {(XLEN/16){rs2[15:0]}};
        err   = off[0];
      end
      2'b10: begin
        be  = 4'b1111;
        err = |off;
      end
      default: err = 1'b1;
    endcase

    // Stores have no unsigned forms; loads reject 110/111.
    if (is_store ? funct3[2] : (funct3[2] & funct3[1])) err = 1'b1;

    case (funct3)
      F3_B:    rdata_ext = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   rdata_ext = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    rdata_ext = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   rdata_ext = {{(XLEN-16){1'b0}}, half_v};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory req/ack transactions from the EX/MEM register,
// stalls upstream while an access is outstanding, and drives the MEM/WB register.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_mem,
  input  logic [XLEN-1:0] alu_result_mem,
  input  logic [XLEN-1:0] rs2_data_mem,
  input  logic [4:0]      rd_mem,
  input  logic [XLEN-1:0] pc_p_4_mem,
  input  logic            register_write_mem,
  input  logic [1:0]      result_src_mem,
  input  logic            mem_write_enable_mem,
  input  logic [2:0]      funct3_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_mem,
  output logic [XLEN-1:0] alu_result_wb,
  output logic [XLEN-1:0] read_data_wb,
  output logic [XLEN-1:0] pc_p_4_wb,
  output logic [4:0]      rd_wb,
  output logic [1:0]      result_src_wb,
  output logic            register_write_wb,
  output logic            valid_wb,
  output logic            misalign_err,
  output logic            timeout_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  mem_state_e      state, state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic            done;
  logic            is_store, is_memop, align_err;
  logic            issue, finish, abort, bad, retire_alu;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c, rdata_ext;

  assign is_store = mem_write_enable_mem;
  assign is_memop = valid_mem & (result_src_mem == RS_LOAD | mem_write_enable_mem);

  load_store_align #(.XLEN(XLEN)) u_align (
    .off       (alu_result_mem[1:0]),
    .funct3    (funct3_mem),
    .is_store  (is_store),
    .rs2       (rs2_data_mem),
    .rdata     (dmem_rdata),
    .be        (be_c),
    .wdata     (wdata_c),
    .rdata_ext (rdata_ext),
    .err       (align_err)
  );

  // done marks the IDLE cycle right after a completed/aborted access: the EX/MEM slot
  // still holds that instruction (it was stalled through the ack), so it must not re-issue.
  always_comb begin
    state_nxt  = state;
    stall_mem  = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    bad        = 1'b0;
    retire_alu = 1'b0;
    case (state)
      IDLE: begin
        if (!done) begin
          if (is_memop) begin
            if (align_err) bad = 1'b1;
            else begin
              stall_mem = 1'b1;
              issue     = 1'b1;
              state_nxt = WAIT;
            end
          end else if (valid_mem) retire_alu = 1'b1;
        end
      end
      WAIT: begin
        stall_mem = 1'b1;
        if (dmem_ack) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      done              <= 1'b0;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_wdata        <= '0;
      dmem_be           <= '0;
      alu_result_wb     <= '0;
      read_data_wb      <= '0;
      pc_p_4_wb         <= '0;
      rd_wb             <= '0;
      result_src_wb     <= '0;
      register_write_wb <= 1'b0;
      valid_wb          <= 1'b0;
      misalign_err      <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      state        <= state_nxt;
      done         <= finish | abort;
      misalign_err <= bad;
      if (abort) timeout_err <= 1'b1;

      if (state == WAIT && !finish && !abort) wait_cnt <= wait_cnt + 1'b1;
      else                                    wait_cnt <= '0;

      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {alu_result_mem[XLEN-1:2], 2'b00};
        dmem_wdata <= wdata_c;
        dmem_be    <= be_c;
      end else if (finish | abort) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
        dmem_be  <= '0;
      end

      if (retire_alu | finish) begin
        alu_result_wb     <= alu_result_mem;
        pc_p_4_wb         <= pc_p_4_mem;
        rd_wb             <= rd_mem;
        result_src_wb     <= result_src_mem;
        register_write_wb <= register_write_mem;
        valid_wb          <= 1'b1;
        read_data_wb      <= (finish && !is_store) ? rdata_ext : '0;
      end else begin
        register_write_wb <= 1'b0;
        valid_wb          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage: a word-array memory model predicts
// WB results and bus traffic; a responder acks requests and a monitor checks retirements.
module tb_mem_access_stage;

  localparam int XLEN = 32;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_mem = 0, register_write_mem = 0, mem_write_enable_mem = 0;
  logic [31:0] alu_result_mem = 0, rs2_data_mem = 0, pc_p_4_mem = 0;
  logic [4:0] rd_mem = 0;
  logic [1:0] result_src_mem = 0;
  logic [2:0] funct3_mem = 0;
  logic dmem_req, dmem_we, dmem_ack, stall_mem;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_be;
  logic [31:0] alu_result_wb, read_data_wb, pc_p_4_wb;
  logic [4:0] rd_wb;
  logic [1:0] result_src_wb;
  logic register_write_wb, valid_wb, misalign_err, timeout_err;

  mem_access_stage #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_mem(valid_mem), .alu_result_mem(alu_result_mem),
    .rs2_data_mem(rs2_data_mem), .rd_mem(rd_mem), .pc_p_4_mem(pc_p_4_mem),
    .register_write_mem(register_write_mem), .result_src_mem(result_src_mem),
    .mem_write_enable_mem(mem_write_enable_mem), .funct3_mem(funct3_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .alu_result_wb(alu_result_wb), .read_data_wb(read_data_wb), .pc_p_4_wb(pc_p_4_wb),
    .rd_wb(rd_wb), .result_src_wb(result_src_wb), .register_write_wb(register_write_wb),
    .valid_wb(valid_wb), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd; logic rw; logic [31:0] alu, rdata, pc4; logic [1:0] src;
  } wb_t;
  typedef struct {
    logic st; logic [31:0] addr, wdata; logic [3:0] be;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  logic [31:0] ram_model[256];
  logic [31:0] ram_bus[256];

  int vectors = 0, miscompares = 0;
  int exp_mis = 0, act_mis = 0;
  bit auto_ack = 1, force_ack = 0;
  int cur_dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks after cur_dly extra WAIT cycles, checks the issued bus fields.
  initial begin
    int cnt;
    bus_t b;
    cnt = 0;
    dmem_ack = 0;
    dmem_rdata = 0;
    forever begin
      @(posedge clk);
      if (force_ack) begin
        dmem_ack = 1;
        dmem_rdata = $urandom;
      end else if (auto_ack && dmem_req && !dmem_ack) begin
        if (cnt >= cur_dly) begin
          cnt = 0;
          dmem_ack = 1;
          dmem_rdata = ram_bus[dmem_addr[9:2]];
          if (bus_q.size() == 0) chk("bus_unexpected_req", 32'd1, 32'd0);
          else begin
            b = bus_q.pop_front();
            chk("bus_we", {31'd0, dmem_we}, {31'd0, b.st});
            chk("bus_addr", dmem_addr, b.addr);
            if (b.st) begin
              chk("bus_be", {28'd0, dmem_be}, {28'd0, b.be});
              chk("bus_wdata", dmem_wdata, b.wdata);
            end
          end
          if (dmem_we)
            for (int i = 0; i < 4; i++)
              if (dmem_be[i]) ram_bus[dmem_addr[9:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
        end else begin
          dmem_ack = 0;
          cnt++;
        end
      end else begin
        dmem_ack = 0;
        cnt = 0;
      end
    end
  end

  // Monitor: every cycle with valid_wb high is one retirement.
  always @(posedge clk) begin
    wb_t e;
    if (misalign_err === 1'b1) act_mis++;
    if (valid_wb === 1'b1) begin
      if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        e = wb_q.pop_front();
        chk("rd_wb", {27'd0, rd_wb}, {27'd0, e.rd});
        chk("register_write_wb", {31'd0, register_write_wb}, {31'd0, e.rw});
        chk("alu_result_wb", alu_result_wb, e.alu);
        chk("read_data_wb", read_data_wb, e.rdata);
        chk("pc_p_4_wb", pc_p_4_wb, e.pc4);
        chk("result_src_wb", {30'd0, result_src_wb}, {30'd0, e.src});
      end
    end
  end

  // Drive one EX/MEM slot, predict its outcome, and hold it until accepted.
  task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [31:0] pc4, input logic rw,
                       input logic [1:0] src, input logic mw, input logic [2:0] f3,
                       input int dly, input bit will_timeout);
    int size, off, idx, stalls, exp_stalls;
    bit memop, legal;
    logic [31:0] w, val, wd;
    wb_t e;
    bus_t b;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    off  = int'(alu[1:0]);
    idx  = int'(alu[9:2]);
    memop = v && (mw || src == 2'b01);
    legal = size != 0 && (off % size) == 0 && (mw ? !f3[2] : !(f3[2] && size == 4));
    exp_stalls = 0;
    e.rd = rd; e.rw = rw; e.alu = alu; e.pc4 = pc4; e.src = src; e.rdata = 0;
    if (v && !memop) wb_q.push_back(e);
    else if (memop && !legal) exp_mis++;
    else if (memop) begin
      exp_stalls = will_timeout ? MAX_WAIT + 1 : dly + 2;
      b.st = mw; b.addr = {alu[31:2], 2'b00}; b.be = 4'(((1 << size) - 1) << off);
      wd = 0;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % size) +: 8];
      b.wdata = wd;
      if (!will_timeout) begin
        bus_q.push_back(b);
        if (mw) begin
          for (int k = 0; k < size; k++) ram_model[idx][8*(off+k) +: 8] = rs2[8*k +: 8];
        end else begin
          w = ram_model[idx];
          val = w >> (8 * off);
          if (size == 1) val = f3[2] ? (val & 32'hFF) : {{24{val[7]}}, val[7:0]};
          if (size == 2) val = f3[2] ? (val & 32'hFFFF) : {{16{val[15]}}, val[15:0]};
          e.rdata = val;
        end
        wb_q.push_back(e);
      end
    end
    cur_dly = dly;
    valid_mem = v; alu_result_mem = alu; rs2_data_mem = rs2; rd_mem = rd; pc_p_4_mem = pc4;
    register_write_mem = rw; result_src_mem = src; mem_write_enable_mem = mw; funct3_mem = f3;
    stalls = 0;
    for (int c = 0; c < 60; c++) begin
      logic s;
      #1 s = stall_mem;
      if (s) stalls++;
      @(posedge clk);
      if (!s) break;
      if (c == 59) chk("accept_budget", 32'd1, 32'd0);
    end
    chk("stall_cycles", stalls, exp_stalls);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_model[i] = $urandom;
      ram_bus[i] = ram_model[i];
    end
    ram_model[8'h80] = 32'h80FF_FFFF;
    ram_bus[8'h80] = 32'h80FF_FFFF;
    repeat (2) @(posedge clk);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_valid_wb", {31'd0, valid_wb}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_read_data_wb", read_data_wb, 32'd0);
    chk("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    rst_n = 1;
    @(posedge clk);

    // Directed: ALU op, SW with 3 extra waits, LB/LBU/LH lane extraction, misaligned LW.
    issue(1, 32'h1234_5678, 0, 5'd5, 32'h44, 1, 2'b00, 0, 3'b000, 0, 0);
    issue(1, 32'h100, 32'hDEAD_BEEF, 5'd0, 32'h48, 0, 2'b00, 1, 3'b010, 3, 0);
    issue(1, 32'h203, 0, 5'd6, 32'h4C, 1, 2'b01, 0, 3'b000, 1, 0);
    issue(1, 32'h203, 0, 5'd7, 32'h50, 1, 2'b01, 0, 3'b100, 0, 0);
    issue(1, 32'h202, 0, 5'd8, 32'h54, 1, 2'b01, 0, 3'b001, 2, 0);
    issue(1, 32'h102, 0, 5'd9, 32'h58, 1, 2'b01, 0, 3'b010, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [31:0] a;
      logic [2:0] f3;
      logic [1:0] src;
      kind = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 9) < 6) a[1:0] = 2'b00;
      src = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      if (kind == 0)
        issue(0, a, $urandom, 5'($urandom), $urandom, 1'($urandom), 2'($urandom), 1'($urandom), f3, 0, 0);
      else if (kind <= 3)
        issue(1, a, $urandom, 5'($urandom), $urandom, 1'($urandom), src, 0, f3, 0, 0);
      else if (kind <= 6)
        issue(1, a, $urandom, 5'($urandom), $urandom, 1'($urandom), 2'b01, 0, f3, $urandom_range(0, 5), 0);
      else
        issue(1, a, $urandom, 5'($urandom), $urandom, 1'($urandom), 2'($urandom), 1, f3, $urandom_range(0, 5), 0);
    end
    valid_mem = 0;
    repeat (3) @(posedge clk);
    chk("misalign_pulses", act_mis, exp_mis);
    chk("timeout_err_clear", {31'd0, timeout_err}, 32'd0);

    // Timeout: no ack ever; then a late ack must change nothing.
    auto_ack = 0;
    issue(1, 32'h40, 0, 5'd3, 32'h60, 1, 2'b01, 0, 3'b010, 0, 1);
    valid_mem = 0;
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    chk("timeout_req_drop", {31'd0, dmem_req}, 32'd0);
    #2 force_ack = 1;
    repeat (3) @(posedge clk);
    #2 force_ack = 0;
    @(posedge clk);
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset during WAIT.
    valid_mem = 1; alu_result_mem = 32'h80; result_src_mem = 2'b01;
    mem_write_enable_mem = 0; funct3_mem = 3'b010; register_write_mem = 1;
    repeat (3) @(posedge clk);
    chk("wait_req_high", {31'd0, dmem_req}, 32'd1);
    #3 rst_n = 0; valid_mem = 0;
    #1;
    chk("async_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rst_wb_outs", {29'd0, valid_wb, register_write_wb, timeout_err}, 32'd0);
    chk("rst_alu_wb", alu_result_wb, 32'd0);
    @(posedge clk);
    rst_n = 1;
    #2 force_ack = 1;
    repeat (3) begin
      @(posedge clk);
      #1 chk("post_rst_ack_req", {31'd0, dmem_req}, 32'd0);
      chk("post_rst_ack_wb", {31'd0, valid_wb}, 32'd0);
    end
    force_ack = 0;
    repeat (2) @(posedge clk);
    chk("wb_queue_empty", wb_q.size(), 32'd0);
    chk("bus_queue_empty", bus_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
